// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM states, default bit
// period and data width.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the receiver: two-flop synchronizer on the
// asynchronous serial pin, a one-cycle delayed copy of the synchronized
// level, and a falling-edge strobe derived from the two.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronize the pin and keep the previous synchronized level; all flops
  // reset to the idle (high) line level so reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the start edge, checks the start bit at
// mid-bit, shifts in eight data bits LSB first and checks the stop bit.
// Good frames update rxbyte with a one-cycle rxvalid pulse; a low stop bit
// gives a one-cycle framing_err pulse and leaves rxbyte untouched.
// Build option: UART_RX_MAJORITY_EN makes every sample a 2-of-3 vote over
// the synchronized line at t-2, t-1 and t instead of the single level at t.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rxvalid,
  output logic       framing_err,
  output logic       busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // Counter starts at 0 in the cycle after the edge, so the mid-start-bit
  // sample (H cycles after the edge) happens at count H-1.
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cfg
    $error("uart_rx: CLKS_PER_BIT must be in 4..65535");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           rxbyte_q, rxbyte_d;
  logic                 rxvalid_q, rxvalid_d;
  logic                 ferr_q, ferr_d;

  logic rx_s;
  logic fall;
  logic sample;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx),
    .rx_s_o (rx_s),
    .fall_o (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago; together with
  // the live rx_s they form the three-sample voting window.
  logic [1:0] hist_q;

  // Shift the synchronized line into the voting history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rxbyte_q  <= '0;
      rxvalid_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rxbyte_q  <= rxbyte_d;
      rxvalid_q <= rxvalid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic: bit timing, sampling decisions and result strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rxbyte_d  = rxbyte_q;
    rxvalid_d = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line already back high at mid-start-bit was a glitch.
          state_d = sample ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sample) begin
            rxbyte_d  = shift_q;
            rxvalid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rxbyte      = rxbyte_q;
  assign rxvalid     = rxvalid_q;
  assign framing_err = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Each scenario builds a per-cycle pin
// waveform, a reference model derives the expected strobes, busy and rxbyte
// from the frame timing rules (edge, mid-bit sample points, stop check),
// and the waveform is then played into the DUT and compared cycle by cycle.
module tb_uart_rx;

  localparam int C    = 16;
  localparam int H    = C / 2;
  localparam int LAT  = 2 + H + 9 * C + 1;   // pin-to-strobe clocks
  localparam int MAXC = 2048;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rxbyte;
  logic       rxvalid;
  logic       framing_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rxbyte      (rxbyte),
    .rxvalid     (rxvalid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Pin waveform: lvl[i] is driven just after clock edge i-1 and the DUT
  // outputs are observed just after edge i (index i).
  logic       lvl [MAXC];
  int         n_cyc;
  logic       ov  [MAXC];
  logic       o_f [MAXC];
  logic       ob  [MAXC];
  logic [7:0] oby [MAXC];
  logic       mv  [MAXC];
  logic       mf  [MAXC];
  logic       mb  [MAXC];
  logic [7:0] mby [MAXC];
  logic [7:0] mnew[MAXC];
  logic [7:0] last_byte;

  task automatic wave_clear();
    n_cyc = 0;
  endtask

  task automatic add_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      lvl[n_cyc] = v;
      n_cyc++;
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input logic stop_bit);
    add_level(1'b0, C);
    for (int i = 0; i < 8; i++) add_level(d[i], C);
    add_level(stop_bit, C);
  endtask

  // Synchronized line level in observation cycle k (two-flop lag).
  function automatic logic rxs_at(input int k);
    if (k < 1 || k - 1 >= n_cyc) return 1'b1;
    return lvl[k-1];
  endfunction

  function automatic logic sample_at(input int t);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(rxs_at(t-2)) + int'(rxs_at(t-1)) + int'(rxs_at(t));
    return (ones >= 2);
`else
    return rxs_at(t);
`endif
  endfunction

  // Frame-level reference: find edges, apply the sample schedule, and mark
  // strobes one cycle after the stop sample.
  task automatic model();
    int k;
    logic [7:0] b;
    for (int j = 0; j < n_cyc; j++) begin
      mv[j] = 1'b0; mf[j] = 1'b0; mb[j] = 1'b0; mnew[j] = 8'h00;
    end
    k = 1;
    while (k < n_cyc) begin
      if (rxs_at(k-1) === 1'b1 && rxs_at(k) === 1'b0) begin
        int e;
        e = k;
        if (sample_at(e + H)) begin
          for (int j = e + 1; j <= e + H && j < n_cyc; j++) mb[j] = 1'b1;
          k = e + H + 1;
        end else begin
          logic [7:0] d;
          int stop;
          stop = e + H + 9 * C;
          for (int i = 0; i < 8; i++) d[i] = sample_at(e + H + (i + 1) * C);
          for (int j = e + 1; j <= stop && j < n_cyc; j++) mb[j] = 1'b1;
          if (stop + 1 < n_cyc) begin
            if (sample_at(stop)) begin
              mv[stop+1]   = 1'b1;
              mnew[stop+1] = d;
            end else begin
              mf[stop+1] = 1'b1;
            end
          end
          k = stop + 1;
        end
      end else begin
        k++;
      end
    end
    b = last_byte;
    for (int j = 0; j < n_cyc; j++) begin
      if (mv[j]) b = mnew[j];
      mby[j] = b;
    end
    last_byte = b;
  endtask

  task automatic play_n(input int n);
    for (int i = 0; i < n; i++) begin
      rx = lvl[i];
      @(posedge clk);
      #1;
      ov[i]  = rxvalid;
      o_f[i] = framing_err;
      ob[i]  = busy;
      oby[i] = rxbyte;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rxvalid, framing_err, busy, rxbyte} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_state got v%0b f%0b b%0b %02h want all zero", rxvalid, framing_err, busy, rxbyte);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_byte = 8'h00;
    $display("test_reset done");
  endtask

  task automatic test_good_byte();
    int s, first, npulse, nbusy_bad;
    wave_clear(); add_level(1'b1, 6); s = n_cyc; add_frame(8'hA5, 1'b1); add_level(1'b1, 6);
    model(); play_n(n_cyc);
    for (int k = 0; k < n_cyc; k++) begin
      n_checks++;
      if ({ov[k], o_f[k], ob[k], oby[k]} !== {mv[k], mf[k], mb[k], mby[k]}) begin
        n_err++;
        $display("FAIL good_byte c%0d got v%0b f%0b b%0b %02h want v%0b f%0b b%0b %02h", k, ov[k], o_f[k], ob[k], oby[k], mv[k], mf[k], mb[k], mby[k]);
      end
    end
    first = -1; npulse = 0;
    for (int k = 0; k < n_cyc; k++) if (ov[k]) begin npulse++; if (first < 0) first = k; end
    // Pin falls just after edge s-1, so LAT clocks later is observation s+LAT-1.
    n_checks++;
    if (npulse != 1 || first - s != LAT - 1) begin
      n_err++;
      $display("FAIL good_latency got pulses %0d at +%0d want 1 at +%0d", npulse, first - s + 1, LAT);
    end
    n_checks++;
    if (first < 0 || oby[first] !== 8'hA5) begin
      n_err++;
      $display("FAIL good_byte_value got %02h want a5", (first < 0) ? 8'hxx : oby[first]);
    end
    nbusy_bad = 0;
    for (int k = s + 2; k < first; k++) if (ob[k] !== 1'b1) nbusy_bad++;
    n_checks++;
    if (nbusy_bad != 0) begin
      n_err++;
      $display("FAIL good_busy got %0d idle cycles want 0", nbusy_bad);
    end
    $display("test_good_byte: pulse at +%0d byte %02h", first - s + 1, (first < 0) ? 8'h00 : oby[first]);
  endtask

  task automatic test_back_to_back();
    int p[$];
    wave_clear(); add_level(1'b1, 5); add_frame(8'h00, 1'b1); add_frame(8'hFF, 1'b1); add_level(1'b1, 6);
    model(); play_n(n_cyc);
    for (int k = 0; k < n_cyc; k++) begin
      n_checks++;
      if ({ov[k], o_f[k], ob[k], oby[k]} !== {mv[k], mf[k], mb[k], mby[k]}) begin
        n_err++;
        $display("FAIL b2b c%0d got v%0b f%0b b%0b %02h want v%0b f%0b b%0b %02h", k, ov[k], o_f[k], ob[k], oby[k], mv[k], mf[k], mb[k], mby[k]);
      end
      if (ov[k]) p.push_back(k);
    end
    n_checks++;
    if (p.size() != 2 || p[1] - p[0] != 10 * C || oby[p[0]] !== 8'h00 || oby[p[1]] !== 8'hFF) begin
      n_err++;
      $display("FAIL b2b_pulses got %0d pulses want 2 spaced %0d with 00,ff", p.size(), 10 * C);
    end
    $display("test_back_to_back: %0d pulses", p.size());
  endtask

  task automatic test_false_start();
    int nbusy, nstrobe;
    wave_clear(); add_level(1'b1, 6); add_level(1'b0, 3); add_level(1'b1, 30);
    model(); play_n(n_cyc);
    nbusy = 0; nstrobe = 0;
    for (int k = 0; k < n_cyc; k++) begin
      n_checks++;
      if ({ov[k], o_f[k], ob[k], oby[k]} !== {mv[k], mf[k], mb[k], mby[k]}) begin
        n_err++;
        $display("FAIL false_start c%0d got v%0b f%0b b%0b %02h want v%0b f%0b b%0b %02h", k, ov[k], o_f[k], ob[k], oby[k], mv[k], mf[k], mb[k], mby[k]);
      end
      if (ob[k]) nbusy++;
      if (ov[k] || o_f[k]) nstrobe++;
    end
    // START occupies the cycles after the edge up to and including the
    // mid-bit sample cycle.
    n_checks++;
    if (nstrobe != 0 || nbusy != H || ob[n_cyc-1] !== 1'b0) begin
      n_err++;
      $display("FAIL false_start_sum got strobes %0d busy %0d want 0 and %0d", nstrobe, nbusy, H);
    end
    $display("test_false_start: busy %0d cycles", nbusy);
  endtask

  task automatic test_framing();
    int nv, nf, fidx;
    wave_clear(); add_level(1'b1, 4);
    add_frame(8'h3C, 1'b1);
    add_frame(8'h55, 1'b0);
    add_level(1'b0, 40);          // line stays low: must not retrigger
    add_level(1'b1, 10);
    add_frame(8'h96, 1'b1);
    add_level(1'b1, 4);
    model(); play_n(n_cyc);
    nv = 0; nf = 0; fidx = -1;
    for (int k = 0; k < n_cyc; k++) begin
      n_checks++;
      if ({ov[k], o_f[k], ob[k], oby[k]} !== {mv[k], mf[k], mb[k], mby[k]}) begin
        n_err++;
        $display("FAIL framing c%0d got v%0b f%0b b%0b %02h want v%0b f%0b b%0b %02h", k, ov[k], o_f[k], ob[k], oby[k], mv[k], mf[k], mb[k], mby[k]);
      end
      if (ov[k]) nv++;
      if (o_f[k]) begin nf++; fidx = k; end
    end
    n_checks++;
    if (nv != 2 || nf != 1 || fidx < 0 || oby[fidx] !== 8'h3C || oby[n_cyc-1] !== 8'h96) begin
      n_err++;
      $display("FAIL framing_sum got valid %0d ferr %0d want 2 and 1 with byte 3c kept", nv, nf);
    end
    $display("test_framing: valid %0d ferr %0d", nv, nf);
  endtask

  task automatic test_reset_mid_frame();
    int s, nv;
    wave_clear(); add_level(1'b1, 4); s = n_cyc; add_frame(8'hC3, 1'b1);
    play_n(s + 5 * C + 8);        // synchronized line is inside data bit 4
    n_checks++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midframe_busy got %0b want 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rxvalid, framing_err, busy, rxbyte} !== 11'd0) begin
      n_err++;
      $display("FAIL midframe_reset got v%0b f%0b b%0b %02h want all zero", rxvalid, framing_err, busy, rxbyte);
    end
    rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_byte = 8'h00;
    wave_clear(); add_level(1'b1, 4); add_frame(8'h81, 1'b1); add_level(1'b1, 4);
    model(); play_n(n_cyc);
    nv = 0;
    for (int k = 0; k < n_cyc; k++) begin
      n_checks++;
      if ({ov[k], o_f[k], ob[k], oby[k]} !== {mv[k], mf[k], mb[k], mby[k]}) begin
        n_err++;
        $display("FAIL after_reset c%0d got v%0b f%0b b%0b %02h want v%0b f%0b b%0b %02h", k, ov[k], o_f[k], ob[k], oby[k], mv[k], mf[k], mb[k], mby[k]);
      end
      if (ov[k]) nv++;
    end
    n_checks++;
    if (nv != 1 || oby[n_cyc-1] !== 8'h81) begin
      n_err++;
      $display("FAIL after_reset_byte got %02h pulses %0d want 81 and 1", oby[n_cyc-1], nv);
    end
    $display("test_reset_mid_frame: byte %02h", oby[n_cyc-1]);
  endtask

  task automatic test_majority();
    int s, bi, vidx;
    logic [7:0] want;
    bi = $urandom_range(0, 7);
    wave_clear(); add_level(1'b1, 4); s = n_cyc; add_frame(8'h00, 1'b1); add_level(1'b1, 4);
    lvl[s + H + (bi + 1) * C] = 1'b1;   // one-clock glitch on the sample point
`ifdef UART_RX_MAJORITY_EN
    want = 8'h00;
`else
    want = 8'h01 << bi;
`endif
    model(); play_n(n_cyc);
    vidx = -1;
    for (int k = 0; k < n_cyc; k++) begin
      n_checks++;
      if ({ov[k], o_f[k], ob[k], oby[k]} !== {mv[k], mf[k], mb[k], mby[k]}) begin
        n_err++;
        $display("FAIL majority c%0d got v%0b f%0b b%0b %02h want v%0b f%0b b%0b %02h", k, ov[k], o_f[k], ob[k], oby[k], mv[k], mf[k], mb[k], mby[k]);
      end
      if (ov[k]) vidx = k;
    end
    n_checks++;
    if (vidx < 0 || oby[vidx] !== want) begin
      n_err++;
      $display("FAIL majority_byte bit %0d got %02h want %02h", bi, (vidx < 0) ? 8'hxx : oby[vidx], want);
    end
    $display("test_majority: glitch on bit %0d byte %02h", bi, (vidx < 0) ? 8'h00 : oby[vidx]);
  endtask

  task automatic test_random();
    int nv, nf;
    wave_clear(); add_level(1'b1, 4);
    for (int f = 0; f < 6; f++) begin
      add_level(1'b1, $urandom_range(0, 12));
      add_frame(8'($urandom), ($urandom_range(0, 3) != 0));
    end
    add_level(1'b1, 8);
    model(); play_n(n_cyc);
    nv = 0; nf = 0;
    for (int k = 0; k < n_cyc; k++) begin
      n_checks++;
      if ({ov[k], o_f[k], ob[k], oby[k]} !== {mv[k], mf[k], mb[k], mby[k]}) begin
        n_err++;
        $display("FAIL random c%0d got v%0b f%0b b%0b %02h want v%0b f%0b b%0b %02h", k, ov[k], o_f[k], ob[k], oby[k], mv[k], mf[k], mb[k], mby[k]);
      end
      if (ov[k]) nv++;
      if (o_f[k]) nf++;
    end
    $display("test_random: %0d cycles valid %0d ferr %0d", n_cyc, nv, nf);
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_back_to_back();
    test_false_start();
    test_framing();
    test_reset_mid_frame();
    test_majority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
